// File: rtl/seq_det_ctrl_if.sv
// seq_det_ctrl_if: configuration handshake, run control, serial input and result outputs
interface seq_det_ctrl_if #(
    parameter int PW = 8,
    parameter int MW = 4,
    parameter int WW = 8
);
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [PW-1:0]         cfg_pattern;
    logic [$clog2(PW)-1:0] cfg_len;
    logic                  cfg_overlap;
    logic [MW-1:0]         cfg_max;
    logic [WW-1:0]         cfg_window;
    logic                  start;
    logic                  abort;
    logic                  x;
    logic                  x_valid;
    logic                  z;
    logic                  busy;
    logic                  done;
    logic [MW-1:0]         match_cnt;
    logic                  timeout;
    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_max, cfg_window,
        output start, abort, x, x_valid,
        input  cfg_ready, z, busy, done, match_cnt, timeout
    );
    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_max, cfg_window,
        input  start, abort, x, x_valid,
        output cfg_ready, z, busy, done, match_cnt, timeout
    );
endinterface

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: configurable serial pattern detector with match/window limits and run control
module seq_det_ctrl #(
    parameter int PW = 8,
    parameter int MW = 4,
    parameter int WW = 8
) (
    input logic           clk,
    input logic           rst_n,
    seq_det_ctrl_if.slave bus
);
    localparam int LW = $clog2(PW);
    localparam int SW = $clog2(PW + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    typedef struct packed {
        logic [PW-1:0] pat;
        logic [LW-1:0] len;
        logic          ovl;
        logic [MW-1:0] max;
        logic [WW-1:0] win;
    } cfg_t;
    state_e        state_q, state_d;
    cfg_t          cfg_q, cfg_d;
    logic [PW-2:0] sr_q, sr_d;
    logic [PW-1:0] sr_n, mask;
    logic [SW-1:0] seen_q, seen_d, seen_n;
    logic [WW-1:0] wcnt_q, wcnt_d, wcnt_n;
    logic [MW-1:0] mcnt_q, mcnt_d, mcnt_n;
    logic          z_q, z_d, to_q, to_d;
    logic          idle, go, step, hit, lim_m, lim_w;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end
    always_comb begin
        state_d = state_q == IDLE ? (bus.start ? RUN : IDLE)
                : state_q == RUN  ? (bus.abort ? IDLE : (lim_m || lim_w) ? DONE : RUN)
                : IDLE;
    end
    always_comb begin
        bus.cfg_ready = state_q == IDLE;
        bus.busy      = state_q == RUN;
        bus.done      = state_q == DONE;
        bus.z         = z_q;
        bus.match_cnt = mcnt_q;
        bus.timeout   = to_q;
    end
    // abort suppresses the bit arriving in the same cycle, so step gates all run updates
    always_comb begin
        idle   = state_q == IDLE;
        go     = idle && bus.start;
        step   = state_q == RUN && bus.x_valid && !bus.abort;
        sr_n   = {sr_q, bus.x};
        seen_n = seen_q == SW'(PW) ? seen_q : seen_q + 1'b1;
        wcnt_n = wcnt_q + 1'b1;
        mcnt_n = &mcnt_q ? mcnt_q : mcnt_q + 1'b1;
        mask   = {~({(PW-1){1'b1}} << cfg_q.len), 1'b1};
        hit    = step && seen_n > SW'(cfg_q.len) && ((sr_n ^ cfg_q.pat) & mask) == '0;
        lim_m  = hit && cfg_q.max != '0 && mcnt_n == cfg_q.max;
        lim_w  = step && cfg_q.win != '0 && wcnt_n == cfg_q.win;
        cfg_d  = idle && bus.cfg_valid
               ? cfg_t'{pat: bus.cfg_pattern, len: bus.cfg_len, ovl: bus.cfg_overlap,
                        max: bus.cfg_max, win: bus.cfg_window}
               : cfg_q;
        sr_d   = go ? '0 : step ? sr_n[PW-2:0] : sr_q;
        seen_d = go ? '0 : step ? ((hit && !cfg_q.ovl) ? '0 : seen_n) : seen_q;
        wcnt_d = go ? '0 : step ? wcnt_n : wcnt_q;
        mcnt_d = go ? '0 : hit ? mcnt_n : mcnt_q;
        to_d   = go ? 1'b0 : step ? (lim_w && !lim_m) : to_q;
        z_d    = hit;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q  <= cfg_t'{pat: PW'(11), len: LW'(3), ovl: 1'b0, max: '0, win: '0};
            sr_q   <= '0;
            seen_q <= '0;
            wcnt_q <= '0;
            mcnt_q <= '0;
            z_q    <= 1'b0;
            to_q   <= 1'b0;
        end else begin
            cfg_q  <= cfg_d;
            sr_q   <= sr_d;
            seen_q <= seen_d;
            wcnt_q <= wcnt_d;
            mcnt_q <= mcnt_d;
            z_q    <= z_d;
            to_q   <= to_d;
        end
    end
endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: scoreboard bench comparing seq_det_ctrl with a bit-history reference model
module tb_seq_det_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int cyc = 0, checks = 0, errors = 0, zcount = 0, dcount = 0;
    typedef struct {int cyc; int mc; bit to;} ev_t;
    ev_t zq[$], dq[$];
    bit m_run, m_done, m_to, m_ovl;
    bit m_hist[$];
    int m_wn, m_mc, m_len, m_max, m_win;
    logic [7:0] m_pat;

    seq_det_ctrl_if #(.PW(8), .MW(4), .WW(8)) bus ();
    seq_det_ctrl #(.PW(8), .MW(4), .WW(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void model_reset();
        m_run = 0; m_done = 0; m_to = 0; m_mc = 0; m_wn = 0;
        m_hist.delete();
        m_pat = 8'b0000_1011; m_len = 4; m_ovl = 0; m_max = 0; m_win = 0;
        zq.delete(); dq.delete();
    endfunction

    // one clock edge of the specified behaviour, given the inputs present at that edge
    function automatic void model(input bit st, input bit ab, input bit xv, input bit xb, input bit cv);
        bit hit;
        ev_t e;
        if (m_done) m_done = 0;
        else if (!m_run) begin
            if (cv) begin
                m_pat = bus.cfg_pattern; m_len = int'(bus.cfg_len) + 1; m_ovl = bus.cfg_overlap;
                m_max = int'(bus.cfg_max); m_win = int'(bus.cfg_window);
            end
            if (st) begin m_run = 1; m_hist.delete(); m_wn = 0; m_mc = 0; m_to = 0; end
        end else if (ab) m_run = 0;
        else if (xv) begin
            m_hist.push_back(xb);
            m_wn++;
            hit = m_hist.size() >= m_len;
            for (int i = 0; i < m_len && hit; i++)
                if (m_hist[m_hist.size() - 1 - i] != m_pat[i]) hit = 0;
            if (hit) begin
                if (m_mc < 15) m_mc++;
                e.cyc = cyc; e.mc = m_mc; e.to = 0;
                zq.push_back(e);
                if (!m_ovl) m_hist.delete();
            end
            if (hit && m_max != 0 && m_mc == m_max) begin
                m_run = 0; m_done = 1; m_to = 0;
            end else if (m_win != 0 && m_wn == m_win) begin
                m_run = 0; m_done = 1; m_to = 1;
            end
            if (m_done) begin e.cyc = cyc; e.mc = m_mc; e.to = m_to; dq.push_back(e); end
        end
    endfunction

    always @(negedge clk) begin : mon
        ev_t e;
        if (bus.z === 1'b1) begin
            zcount++;
            if (zq.size() == 0) chk("z_unexpected", int'(bus.z), 0);
            else begin
                e = zq.pop_front();
                chk("z_cycle", cyc, e.cyc);
                chk("z_match_cnt", int'(bus.match_cnt), e.mc);
            end
        end else if (zq.size() != 0 && zq[0].cyc <= cyc) begin
            e = zq.pop_front();
            chk("z_missing", int'(bus.z), 1);
        end
        if (bus.done === 1'b1) begin
            dcount++;
            if (dq.size() == 0) chk("done_unexpected", int'(bus.done), 0);
            else begin
                e = dq.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("done_match_cnt", int'(bus.match_cnt), e.mc);
                chk("done_timeout", int'(bus.timeout), int'(e.to));
            end
        end else if (dq.size() != 0 && dq[0].cyc <= cyc) begin
            e = dq.pop_front();
            chk("done_missing", int'(bus.done), 1);
        end
        chk("busy", int'(bus.busy), int'(m_run));
        chk("cfg_ready", int'(bus.cfg_ready), int'(!m_run && !m_done));
        chk("match_cnt", int'(bus.match_cnt), m_mc);
        chk("timeout", int'(bus.timeout), int'(m_to));
    end

    task automatic tick(input bit st, input bit ab, input bit xv, input bit xb, input bit cv);
        bus.start = st; bus.abort = ab; bus.x_valid = xv; bus.x = xb; bus.cfg_valid = cv;
        @(posedge clk);
        #1;
        model(st, ab, xv, xb, cv);
        bus.start = 0; bus.abort = 0; bus.x_valid = 0; bus.x = 0; bus.cfg_valid = 0;
    endtask

    // '0'/'1' are valid bits, '_' is an idle cycle with x=1 but x_valid low
    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) tick(0, 0, s[i] != "_", s[i] != "0", 0);
    endtask

    task automatic set_cfg(input logic [7:0] p, input logic [2:0] l, input bit o,
                           input logic [3:0] mx, input logic [7:0] w);
        bus.cfg_pattern = p; bus.cfg_len = l; bus.cfg_overlap = o; bus.cfg_max = mx; bus.cfg_window = w;
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_z"}, int'(bus.z), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_cnt"}, int'(bus.match_cnt), 0);
        chk({tag, "_timeout"}, int'(bus.timeout), 0);
        chk({tag, "_ready"}, int'(bus.cfg_ready), 1);
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 0;
        #1 model_reset();
        rst_chk(tag);
        @(negedge clk);
        #2 rst_n = 1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int z0, d0;
        bus.start = 0; bus.abort = 0; bus.x_valid = 0; bus.x = 0; bus.cfg_valid = 0;
        set_cfg(8'h00, 3'd0, 0, 4'd0, 8'd0);
        model_reset();
        #1 rst_chk("por");
        #11 rst_n = 1;
        // default config, non-overlapping 1011
        z0 = zcount;
        tick(1, 0, 0, 0, 0);
        send("1011011");
        tick(0, 1, 0, 0, 0);
        chk("t040_z", zcount - z0, 1);
        chk("t040_cnt", int'(bus.match_cnt), 1);
        // overlap with config offered alongside start
        set_cfg(8'h0B, 3'd3, 1, 4'd0, 8'd0);
        z0 = zcount;
        tick(1, 0, 0, 0, 1);
        send("1011011");
        tick(0, 1, 0, 0, 0);
        chk("t041_z", zcount - z0, 2);
        chk("t041_cnt", int'(bus.match_cnt), 2);
        // match limit
        set_cfg(8'h0B, 3'd3, 0, 4'd2, 8'd0);
        z0 = zcount; d0 = dcount;
        tick(1, 0, 0, 0, 1);
        send("10111011");
        tick(0, 0, 0, 0, 0);
        chk("t042_z", zcount - z0, 2);
        chk("t042_done", dcount - d0, 1);
        chk("t042_busy", int'(bus.busy), 0);
        chk("t042_timeout", int'(bus.timeout), 0);
        chk("t042_cnt", int'(bus.match_cnt), 2);
        // window limit with x_valid gaps
        set_cfg(8'h07, 3'd2, 0, 4'd0, 8'd5);
        z0 = zcount; d0 = dcount;
        tick(1, 0, 0, 0, 1);
        send("0_0__0_0");
        chk("t043_busy", int'(bus.busy), 1);
        send("_0");
        tick(0, 0, 0, 0, 0);
        chk("t043_done", dcount - d0, 1);
        chk("t043_timeout", int'(bus.timeout), 1);
        chk("t043_cnt", int'(bus.match_cnt), 0);
        chk("t043_z", zcount - z0, 0);
        // match and window limits on the same bit; start/abort during DONE ignored
        set_cfg(8'h0B, 3'd3, 0, 4'd1, 8'd4);
        d0 = dcount;
        tick(1, 0, 0, 0, 1);
        send("1011");
        tick(1, 1, 0, 0, 0);
        chk("t044_done", dcount - d0, 1);
        chk("t044_timeout", int'(bus.timeout), 0);
        chk("t044_cnt", int'(bus.match_cnt), 1);
        chk("t044_busy", int'(bus.busy), 0);
        // config offered in RUN is refused; abort beats the window limit
        set_cfg(8'h0B, 3'd3, 0, 4'd0, 8'd6);
        tick(1, 0, 0, 0, 1);
        send("11");
        set_cfg(8'h01, 3'd0, 1, 4'd1, 8'd0);
        tick(0, 0, 1, 0, 1);
        chk("t045_ready", int'(bus.cfg_ready), 0);
        send("11");
        d0 = dcount;
        tick(0, 1, 1, 1, 0);
        chk("t045_busy", int'(bus.busy), 0);
        chk("t045_cnt", int'(bus.match_cnt), 1);
        tick(0, 0, 0, 0, 0);
        chk("t045_nodone", dcount - d0, 0);
        tick(0, 0, 0, 0, 1);
        z0 = zcount; d0 = dcount;
        tick(1, 0, 0, 0, 0);
        send("1");
        tick(0, 0, 0, 0, 0);
        chk("t045_newcfg_z", zcount - z0, 1);
        chk("t045_newcfg_done", dcount - d0, 1);
        // reset in the middle of a run restores defaults
        set_cfg(8'h0B, 3'd3, 0, 4'd0, 8'd0);
        tick(1, 0, 0, 0, 1);
        send("1011");
        async_reset("t045_rst");
        set_cfg(8'hFF, 3'd7, 1, 4'd3, 8'd9);
        z0 = zcount;
        tick(1, 0, 0, 0, 0);
        send("01011");
        tick(0, 1, 0, 0, 0);
        chk("t045_default_z", zcount - z0, 1);
        // random traffic against the model
        for (int n = 0; n < 20000; n++) begin
            if ($urandom_range(0, 15) == 0)
                set_cfg(8'($urandom), $urandom_range(0, 1) == 1 ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7)),
                        1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
                        $urandom_range(0, 2) == 0 ? 8'd0 : 8'($urandom_range(1, 40)));
            if ($urandom_range(0, 2999) == 0) async_reset("rnd_rst");
            tick($urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
        end
        tick(0, 1, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        chk("z_leftover", zq.size(), 0);
        chk("done_leftover", dq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 The block SHALL have parameter PW, default 8, giving the maximum pattern width in bits.
REQ-002 The block SHALL have parameter MW, default 4, giving the match-count width.
REQ-003 The block SHALL have parameter WW, default 8, giving the window-count width.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 cfg_valid  input  1  configuration offer.
REQ-007 cfg_ready  output  1  configuration accept; high exactly when the FSM is IDLE.
REQ-008 cfg_pattern  input  PW  target pattern; bit len-1 is the first serial bit, bit 0 the last.
REQ-009 cfg_len  input  clog2(PW)  pattern length minus one (length 1..PW).
REQ-010 cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-011 cfg_max  input  MW  match limit; 0 = unlimited.
REQ-012 cfg_window  input  WW  bit-window limit; 0 = unlimited.
REQ-013 start  input  1  begin a run; sampled only in IDLE.
REQ-014 abort  input  1  end a run without done.
REQ-015 x  input  1  serial data bit.
REQ-016 x_valid  input  1  x is valid this cycle.
REQ-017 z  output  1  registered match pulse.
REQ-018 busy  output  1  high in RUN.
REQ-019 done  output  1  one-cycle run-completion pulse.
REQ-020 match_cnt  output  MW  matches in current/last run.
REQ-021 timeout  output  1  last run ended on window limit.

Function
REQ-022 The FSM SHALL have states IDLE, RUN, DONE.
REQ-023 Config SHALL be captured on any edge where cfg_valid and cfg_ready are both high; otherwise held.
REQ-024 cfg_valid and start high together in IDLE SHALL capture the new config and start a run that uses it from its first bit.
REQ-025 IDLE with start high SHALL go to RUN, clearing the shift register, bits-seen count, window count, match_cnt, and timeout.
REQ-026 In RUN, each x_valid cycle SHALL shift x into shift-register bit 0, increment the window count, and increment the bits-seen count (saturating at PW); cycles without x_valid SHALL change nothing.
REQ-027 A match SHALL occur on an x_valid cycle when the post-shift bits-seen count is at least len and the low len bits of the post-shift register equal the low len bits of the pattern.
REQ-028 On a match, z SHALL be 1 in the following cycle only, and match_cnt SHALL increment, saturating at 2^MW-1.
REQ-029 On a match with overlap=0, bits-seen SHALL reset to 0; with overlap=1, it SHALL be retained.
REQ-030 RUN SHALL go to DONE when a match makes match_cnt equal cfg_max (cfg_max non-zero), with timeout=0.
REQ-031 RUN SHALL otherwise go to DONE when the window count reaches cfg_window (cfg_window non-zero), with timeout=1.
REQ-032 If the match limit and window limit coincide, the match limit SHALL win: match counted, timeout=0.
REQ-033 abort in RUN SHALL go to IDLE next edge with no done; that cycle's bit, if any, SHALL be discarded; match_cnt and timeout SHALL be held.
REQ-034 abort SHALL take priority over both limits in the same cycle.
REQ-035 DONE SHALL last one cycle with done=1, then go to IDLE; match_cnt and timeout SHALL hold until the next start.
REQ-036 start in RUN or DONE SHALL be ignored; abort in IDLE or DONE SHALL be ignored.

Reset
REQ-037 rst_n low SHALL immediately force IDLE: z=0, busy=0, done=0, match_cnt=0, timeout=0, cfg_ready=1.
REQ-038 Reset SHALL load config pattern=8'b0000_1011, len=3, overlap=0, max=0, window=0.
REQ-039 Reset mid-run SHALL discard all run state with no done pulse.

Verification
REQ-040 After reset, start, then bits 1,0,1,1,0,1,1 -> z once, one cycle after the 4th bit; match_cnt=1 (non-overlap).
REQ-041 Config overlap=1 with pattern 1011, then bits 1,0,1,1,0,1,1 -> z after bits 4 and 7; match_cnt=2.
REQ-042 Config max=2, window=0, then repeated 1011 -> done one cycle after the 2nd z; busy falls; timeout=0; match_cnt=2.
REQ-043 Config window=5, pattern 111 len=2, bits 0,0,0,0,0 -> done after the 5th valid bit; timeout=1; match_cnt=0; gaps in x_valid do not advance the window.
REQ-044 Config max=1, window=4, pattern 1011, bits 1,0,1,1 -> done with timeout=0, match_cnt=1 (coincidence rule).
REQ-045 abort mid-run, then cfg_valid in RUN -> no done, cfg_ready=0 during RUN; config captured only after return to IDLE; rst_n pulse mid-run clears all outputs at once.
